mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one 2-stage pipelined 15-bit signed multiplier among NREQ independent requesters.
- Round-robin arbitration, valid/ready handshake per requester, requester-ID tag carried alongside each operation.
- One result port with backpressure; the whole multiplier pipeline stalls through its clock enable.
- Sits between HLS-generated compute loops and the shared multiplier resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 15, operand and result width (signed).
- TAGW, 2, tag width; must satisfy 2^TAGW >= NREQ.
- CNTW, 16, width of the issued-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge).
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*DW  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*DW  packed operand B.
- req_ready  out  NREQ  one-hot or zero; accept strobe.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  DW  low DW bits of signed product (wraps).
- res_ovf  out  1  full product does not fit in DW-bit signed.
- res_tag  out  TAGW  index of the originating requester.
- busy  out  1  any operation in flight (v1|v2).
- issued_cnt  out  CNTW  total accepted operations; wraps modulo 2^CNTW.

Behaviour:
- Pipeline: stage1 = operand registers (valid v1, tag t1); stage2 = product register (valid v2, tag t2).
- adv = ~v2 | res_ready. adv drives the multiplier ce and all valid/tag shifts together.
- When adv=0, everything holds: operands, product, tags, valids.
- Grant: when adv=1, pick the first requester with req_valid set, scanning from rr_ptr upward modulo NREQ.
  - req_ready[i]=1 only for the granted i; combinational from req_valid, rr_ptr and adv.
  - req_ready is all-zero when adv=0 or no request is pending.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - Requesters must hold req_valid and operands until accepted.
  - The arbiter never depends on req_valid dropping.
- On transfer by i:
  - v1 <= 1, t1 <= i, operands are muxed into the multiplier.
  - rr_ptr <= (i+1) mod NREQ.
  - issued_cnt increments.
- On adv=1 with no transfer: v1 <= 0; rr_ptr unchanged.
- Stage advance: on adv=1, v2 <= v1 and t2 <= t1.
- Latency: a transfer at edge T gives res_valid=1 after edge T+2 when unstalled.
- Throughput: one operation per cycle.
- A result is consumed when res_valid & res_ready. Results stay stable while res_valid=1 & res_ready=0.
- Result arithmetic:
  - Full product P = signed(a)*signed(b), 2*DW bits.
  - res_data = P[DW-1:0].
  - res_ovf = 1 if P < -2^(DW-1) or P > 2^(DW-1)-1.
- Boundary: (-16384)*(-16384) = 2^28 → res_data=0, res_ovf=1.
- Simultaneous events:
  - Accept and consume in the same cycle is legal; the pipeline stays full at one op/cycle.
  - Several req_valid set at once: exactly one is granted per cycle.
  - Starvation-free: each pending requester is served within NREQ grants.
- Reset values (reset=0 at a clk edge): v1=v2=0, rr_ptr=0, issued_cnt=0, res_valid=0, req_ready=0, busy=0.
  - res_data, res_ovf and res_tag are forced to 0 while v2=0.
  - Reset mid-operation discards in-flight results; no partial result is ever presented.
- Requester indices >= NREQ do not exist; tag values >= NREQ are never produced.

Decomposition:
- Shared package mul_share_pkg:
  - constant DW=15;
  - typedef operand_t (signed DW) and product_t (signed 2*DW);
  - typedef tag_t sized by TAGW;
  - function sat_check(product_t) → overflow bit.
- Sub-module mul_share_dsp_pipe:
  - 2-stage registered signed multiplier (operand regs, then product reg) with ce;
  - full-width product output;
  - no reset on the data path.
- The arbiter, valid/tag shadow pipeline and counter live in the top module.

Test Plan:
- Single request: requester 2 presents a=100, b=-3 → req_ready[2]=1 same cycle; 2 cycles later res_valid=1, res_data=-300, res_tag=2, res_ovf=0, issued_cnt=1.
- All 4 requesters valid continuously, res_ready=1 → grants in order 0,1,2,3,0,… one per cycle; results back-to-back in the same tag order; busy=1 throughout.
- Backpressure: two ops issued, res_ready held 0 for 5 cycles → res_valid stays 1 with constant data/tag; req_ready=0 throughout; on release the second result follows the next cycle.
- Overflow: a=-16384, b=-16384 → res_data=0, res_ovf=1. Then a=16383, b=1 → res_data=16383, res_ovf=0.
- Reset mid-operation: issue 2 ops, drive reset=0 one cycle before the first result → res_valid=0, issued_cnt=0, rr_ptr=0; the next grant goes to the lowest-indexed valid requester.
- Counter wrap: preload by issuing 65536 ops → issued_cnt returns to 0; no loss of results.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// DW here must match the DW parameter of mul_share_arbiter.
package mul_share_pkg;

    localparam int DW   = 15;
    localparam int TAGW = 2;

    typedef logic signed [DW-1:0]   operand_t;
    typedef logic signed [2*DW-1:0] product_t;
    typedef logic [TAGW-1:0]        tag_t;

    // The product fits in DW signed bits only when its top DW+1 bits are pure sign extension.
    function automatic logic sat_check(product_t p);
        logic [DW:0] top;
        top = p[2*DW-1:DW-1];
        return (top != '0) && (top != '1);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester and result bundle of the shared multiplier; slave is the arbiter side.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 15,
    parameter int TAGW = 2,
    parameter int CNTW = 16
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [DW-1:0]      res_data;
    logic               res_ovf;
    logic [TAGW-1:0]    res_tag;
    logic               busy;
    logic [CNTW-1:0]    issued_cnt;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_ovf, res_tag, busy, issued_cnt
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_ovf, res_tag, busy, issued_cnt
    );

endinterface

// File: rtl/mul_share_dsp_pipe.sv
// Two-stage signed multiplier: operand registers, then product register, both gated by ce.
module mul_share_dsp_pipe
    import mul_share_pkg::*;
(
    input  logic     clk,
    input  logic     ce_i,
    input  operand_t a_i,
    input  operand_t b_i,
    output product_t p_o
);

    operand_t a_q;
    operand_t b_q;
    product_t p_q;

    // NOTE: no reset here on purpose; validity is tracked by the control pipeline,
    // so the data registers map straight onto DSP input/output registers.
    always_ff @(posedge clk) begin
        if (ce_i) begin
            a_q <= a_i;
            b_q <= b_i;
            p_q <= product_t'(a_q) * product_t'(b_q);
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters,
// with a valid/tag shadow pipeline that stalls as a whole on result backpressure.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = mul_share_pkg::DW,
    parameter int TAGW = mul_share_pkg::TAGW,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                reset,
    mul_share_arbiter_if.slave  bus
);

    logic            adv;
    logic            v1_q, v1_d, v2_q, v2_d;
    logic [TAGW-1:0] t1_q, t1_d, t2_q, t2_d;
    logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] grant;
    logic            gnt_found;
    logic [TAGW-1:0] gnt_idx;
    operand_t        a_mux;
    operand_t        b_mux;
    product_t        prod;

    assign adv = ~v2_q | bus.res_ready;

    // NOTE: every signal gets a default before the scan so no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        a_mux     = '0;
        b_mux     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found  = 1'b1;
                gnt_idx    = TAGW'(idx);
                grant[idx] = 1'b1;
                a_mux      = operand_t'(bus.req_a[idx*DW +: DW]);
                b_mux      = operand_t'(bus.req_b[idx*DW +: DW]);
            end
        end
        // A stalled pipe or an asserted reset must never complete a handshake.
        if (!adv || !reset) begin
            grant     = '0;
            gnt_found = 1'b0;
        end
    end

    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (adv) begin
            v2_d = v1_q;
            t2_d = t1_q;
            v1_d = gnt_found;
            if (gnt_found) begin
                t1_d     = gnt_idx;
                rr_ptr_d = (gnt_idx == TAGW'(NREQ-1)) ? '0 : gnt_idx + TAGW'(1);
                cnt_d    = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            t1_q     <= '0;
            t2_q     <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    mul_share_dsp_pipe u_dsp (
        .clk  (clk),
        .ce_i (adv),
        .a_i  (a_mux),
        .b_i  (b_mux),
        .p_o  (prod)
    );

    // Data-path registers are never reset, so results are masked until v2 confirms them.
    assign bus.req_ready  = grant;
    assign bus.res_valid  = v2_q;
    assign bus.res_data   = v2_q ? prod[DW-1:0] : '0;
    assign bus.res_ovf    = v2_q & sat_check(prod);
    assign bus.res_tag    = v2_q ? t2_q : '0;
    assign bus.busy       = v1_q | v2_q;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed table-driven bench for mul_share_arbiter plus reset and counter-wrap sequences.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 15;
    localparam int TAGW = 2;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW), .CNTW(CNTW)) bus ();

    mul_share_arbiter #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic               rst_n;
        logic [NREQ-1:0]    valid;
        logic [NREQ*DW-1:0] a;
        logic [NREQ*DW-1:0] b;
        logic               res_ready;
        logic [NREQ-1:0]    exp_ready;
        logic               exp_rv;
        logic [DW-1:0]      exp_data;
        logic               exp_ovf;
        logic [TAGW-1:0]    exp_tag;
        logic               exp_busy;
        logic [CNTW-1:0]    exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec    = 0;
    int   n_miscmp = 0;

    function automatic logic [NREQ*DW-1:0] pk(int x0, int x1, int x2, int x3);
        return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
    endfunction

    function automatic void add(logic rst_n, logic [NREQ-1:0] valid, logic [NREQ*DW-1:0] a,
                                logic [NREQ*DW-1:0] b, logic rr, logic [NREQ-1:0] er,
                                logic erv, int ed, logic eo, int et, logic eb, int ec);
        vec_t v;
        v.rst_n     = rst_n;
        v.valid     = valid;
        v.a         = a;
        v.b         = b;
        v.res_ready = rr;
        v.exp_ready = er;
        v.exp_rv    = erv;
        v.exp_data  = DW'(ed);
        v.exp_ovf   = eo;
        v.exp_tag   = TAGW'(et);
        v.exp_busy  = eb;
        v.exp_cnt   = CNTW'(ec);
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int r);
        reset         = v.rst_n;
        bus.req_valid = v.valid;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.res_ready = v.res_ready;
        #1;
        check($sformatf("row%0d.req_ready", r),  32'(bus.req_ready),  32'(v.exp_ready));
        check($sformatf("row%0d.res_valid", r),  32'(bus.res_valid),  32'(v.exp_rv));
        check($sformatf("row%0d.res_data", r),   32'(bus.res_data),   32'(v.exp_data));
        check($sformatf("row%0d.res_ovf", r),    32'(bus.res_ovf),    32'(v.exp_ovf));
        check($sformatf("row%0d.res_tag", r),    32'(bus.res_tag),    32'(v.exp_tag));
        check($sformatf("row%0d.busy", r),       32'(bus.busy),       32'(v.exp_busy));
        check($sformatf("row%0d.issued_cnt", r), 32'(bus.issued_cnt), 32'(v.exp_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q[$];
        int got;
        int errs;
        int e;

        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res_valid",  32'(bus.res_valid),  32'(0));
        check("rst.busy",       32'(bus.busy),       32'(0));
        check("rst.issued_cnt", 32'(bus.issued_cnt), 32'(0));
        check("rst.res_data",   32'(bus.res_data),   32'(0));
        check("rst.res_tag",    32'(bus.res_tag),    32'(0));

        // Single request from requester 2: 100 * -3.
        add(1, 4'b0100, pk(0, 0, 100, 0), pk(0, 0, -3, 0), 1, 4'b0100, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 1, 1);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, -300, 0, 2, 1, 1);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 0, 1);
        // All four valid, pointer starts at 3: products 20, 60, 120, 200 by tag.
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b1000, 0, 0, 0, 0, 0, 1);
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b0001, 0, 0, 0, 0, 1, 2);
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b0010, 1, 200, 0, 3, 1, 3);
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b0100, 1, 20, 0, 0, 1, 4);
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b1000, 1, 60, 0, 1, 1, 5);
        add(1, 4'b1111, pk(10, 20, 30, 40), pk(2, 3, 4, 5), 1, 4'b0001, 1, 120, 0, 2, 1, 6);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, 200, 0, 3, 1, 7);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, 20, 0, 0, 1, 7);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 0, 7);
        // Backpressure: 7*11 and -9*13 issued, result held 5 cycles while requester 0 waits.
        add(1, 4'b1010, pk(0, 7, 0, -9), pk(0, 11, 0, 13), 1, 4'b0010, 0, 0, 0, 0, 0, 7);
        add(1, 4'b1000, pk(0, 7, 0, -9), pk(0, 11, 0, 13), 0, 4'b1000, 0, 0, 0, 0, 1, 8);
        for (int i = 0; i < 5; i++) begin
            add(1, 4'b0001, pk(5, 0, 0, 0), pk(5, 0, 0, 0), 0, 4'b0000, 1, 77, 0, 1, 1, 9);
        end
        add(1, 4'b0001, pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1, 4'b0001, 1, 77, 0, 1, 1, 9);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, -117, 0, 3, 1, 10);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, 25, 0, 0, 1, 10);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 0, 10);
        // Overflow boundaries: 2^28, 16383, 40000 (wraps to 7232), -16384.
        add(1, 4'b0010, pk(0, -16384, 0, 0), pk(0, -16384, 0, 0), 1, 4'b0010, 0, 0, 0, 0, 0, 10);
        add(1, 4'b0100, pk(0, 0, 16383, 0), pk(0, 0, 1, 0), 1, 4'b0100, 0, 0, 0, 0, 1, 11);
        add(1, 4'b1000, pk(0, 0, 0, 200), pk(0, 0, 0, 200), 1, 4'b1000, 1, 0, 1, 1, 1, 12);
        add(1, 4'b0001, pk(-16384, 0, 0, 0), pk(1, 0, 0, 0), 1, 4'b0001, 1, 16383, 0, 2, 1, 13);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, 7232, 1, 3, 1, 14);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, -16384, 0, 0, 1, 14);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 0, 14);
        // Reset with two ops in flight; afterwards the lowest valid index wins from pointer 0.
        add(1, 4'b0110, pk(0, 3, 4, 0), pk(0, 5, 6, 0), 1, 4'b0010, 0, 0, 0, 0, 0, 14);
        add(1, 4'b0100, pk(0, 3, 4, 0), pk(0, 5, 6, 0), 1, 4'b0100, 0, 0, 0, 0, 1, 15);
        add(0, 4'b0000, '0, '0, 0, 4'b0000, 1, 15, 0, 1, 1, 16);
        add(1, 4'b1100, pk(0, 0, -2, 9), pk(0, 0, 8, 9), 1, 4'b0100, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1000, pk(0, 0, -2, 9), pk(0, 0, 8, 9), 1, 4'b1000, 0, 0, 0, 0, 1, 1);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, -16, 0, 2, 1, 2);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 1, 81, 0, 3, 1, 2);
        add(1, 4'b0000, '0, '0, 1, 4'b0000, 0, 0, 0, 0, 0, 2);

        for (int r = 0; r < tbl.size(); r++) begin
            apply(tbl[r], r);
        end

        // Counter wrap: exactly 2^16 back-to-back ops from requester 0 after a fresh reset.
        reset         = 1'b0;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        got   = 0;
        errs  = 0;
        for (int i = 0; i < 65536 + 6; i++) begin
            bus.res_ready = 1'b1;
            if (i < 65536) begin
                bus.req_valid = 4'b0001;
                bus.req_a     = pk((i % 200) - 100, 0, 0, 0);
                bus.req_b     = pk(7, 0, 0, 0);
            end else begin
                bus.req_valid = '0;
            end
            #1;
            if (i == 65535) begin
                check("wrap.cnt_before", 32'(bus.issued_cnt), 32'(65535));
            end
            if (bus.res_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    errs++;
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_data !== DW'(e) || bus.res_tag !== '0 || bus.res_ovf !== 1'b0) begin
                        errs++;
                    end
                end
            end
            if (i < 65536) begin
                if (bus.req_ready !== 4'b0001) begin
                    errs++;
                end else begin
                    exp_q.push_back(((i % 200) - 100) * 7);
                end
            end
            @(posedge clk);
            #1;
        end
        check("wrap.results",  32'(got),            32'(65536));
        check("wrap.errors",   32'(errs),           32'(0));
        check("wrap.cnt",      32'(bus.issued_cnt), 32'(0));
        check("wrap.busy",     32'(bus.busy),       32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
